// File: rtl/pwm_pkg.sv
// Shared constants for the PWM input-capture block: FSM encoding, default
// counter width and the counter saturation value.
package pwm_pkg;

  localparam int PWM_WIDTH_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  // Largest value a w-bit measurement counter may reach; hitting it means a stuck input.
  function automatic logic [63:0] cnt_sat(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Input conditioning for pwm_capture: synchronizer, optional stability filter
// (PWM_CAPTURE_FILTER_EN), polarity normalization and rise/fall pulses.
module pwm_input_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic clk_psc_i,
  input  logic rst_n_i,
  input  logic pol_i,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   level;
  logic                   norm;
  logic                   norm_p1;

  // Stage 0: metastability synchronizer
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_i};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] stab_cnt;
  logic           filt_q;

  // Accept a new level only after it has differed from the held one for FILTER_LEN cycles.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stab_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (sync_p0[SYNC_STAGES-1] == filt_q) begin
      stab_cnt <= '0;
    end else if (stab_cnt == FCW'(FILTER_LEN - 1)) begin
      stab_cnt <= '0;
      filt_q   <= sync_p0[SYNC_STAGES-1];
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_p0[SYNC_STAGES-1];
`endif

  assign norm = level ^ pol_i;

  // Stage 1: one-cycle delay of the normalized level for edge detection
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      norm_p1 <= 1'b0;
    end else begin
      norm_p1 <= norm;
    end
  end

  assign rise_o = norm & ~norm_p1;
  assign fall_o = ~norm & norm_p1;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and active time of pwm_i in clock cycles
// and hands results out with valid/ack. Optional input filter: PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             pol_i,
  input  logic             pwm_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] duty_o,
  output logic             valid_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam logic [WIDTH-1:0] CNT_SAT = WIDTH'(cnt_sat(WIDTH));

  logic             rise;
  logic             fall;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] high_q;
  logic             arm_start;
  logic             res_load;
  logic             cap_high;
  logic             to_hit;

  pwm_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_sync (
    .clk_psc_i(clk_psc_i),
    .rst_n_i  (rst_n_i),
    .pol_i    (pol_i),
    .pwm_i    (pwm_i),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM:  if (rise) state_d = ST_MEAS;
        ST_MEAS: if (!rise && (cnt_q == CNT_SAT)) state_d = ST_ARM;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A rise outranks saturation: a period ending exactly at the limit still counts.
  always_comb begin
    arm_start = 1'b0;
    res_load  = 1'b0;
    cap_high  = 1'b0;
    to_hit    = 1'b0;
    if (en_i) begin
      case (state_q)
        ST_ARM: begin
          arm_start = rise;
        end
        ST_MEAS: begin
          res_load = rise;
          to_hit   = !rise && (cnt_q == CNT_SAT);
          cap_high = fall && !to_hit;
        end
        default: ;
      endcase
    end
  end

  // Measurement counters
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      high_q <= '0;
    end else if (!en_i || (state_q == ST_IDLE)) begin
      cnt_q  <= '0;
      high_q <= '0;
    end else if (arm_start || res_load) begin
      cnt_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
      high_q <= '0;
    end else if (to_hit) begin
      cnt_q  <= '0;
      high_q <= '0;
    end else if (state_q == ST_MEAS) begin
      cnt_q <= cnt_q + 1'b1;
      if (cap_high) begin
        high_q <= cnt_q;
      end
    end
  end

  // Result registers keep their last value across enable changes.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_o <= '0;
      duty_o   <= '0;
    end else if (res_load) begin
      period_o <= cnt_q;
      duty_o   <= high_q;
    end
  end

  // Handshake and status flags
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else if (!en_i) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (res_load) begin
        valid_o <= 1'b1;
        if (valid_o && !ack_i) begin
          overrun_o <= 1'b1;
        end
      end else if (ack_i) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end

      if (to_hit) begin
        timeout_o <= 1'b1;
      end else if (arm_start || res_load) begin
        timeout_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Input-capture block: the decode side of the PWM output path.
- Samples an external PWM waveform and measures its period and active-time in clk_psc_i cycles.
- Presents each completed measurement with a valid/ack handshake to the register block.
- Sits beside the PWM generator in the timer subsystem. Used for loopback self-test and for external duty/frequency measurement.

Parameters:
- WIDTH, 16, width of the period/duty counters and results.
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).
- FILTER_LEN, 4, cycles the input must be stable before a level is accepted (used only with the optional filter).

Ports:
- clk_psc_i  input  1  single clock, prescaled system clock.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- en_i  input  1  capture enable; low forces IDLE.
- pol_i  input  1  0: active level is high; 1: active level is low (input inverted before edge detect).
- pwm_i  input  1  asynchronous PWM input.
- ack_i  input  1  consumer acknowledge; clears valid_o and overrun_o.
- period_o  output  WIDTH  last measured period, in clk cycles.
- duty_o  output  WIDTH  last measured active time, in clk cycles.
- valid_o  output  1  new measurement available (level, held until ack).
- overrun_o  output  1  a measurement was overwritten while unacknowledged.
- timeout_o  output  1  no edge seen for 2^WIDTH-1 cycles.

Behaviour:
- Reset: every output is 0, all internal flops are 0, state = IDLE.
- Input path:
  - pwm_i passes through SYNC_STAGES flops and is then XORed with pol_i, giving the normalized signal s.
  - rise/fall are single-cycle pulses from a one-flop delay of s.
  - Latency from pwm_i to the edge pulse is SYNC_STAGES+1 cycles.
- State machine IDLE, ARM, MEAS:
  - IDLE: cnt=0. When en_i=1, go to ARM.
  - ARM: wait for rise; fall is ignored. On rise: cnt<=1, go to MEAS.
  - MEAS:
    - Each cycle cnt<=cnt+1.
    - On fall: high_r<=cnt.
    - On rise: period_o<=cnt, duty_o<=high_r, set valid_o, cnt<=1, high_r<=0, stay in MEAS.
  - Any state: en_i=0 returns to IDLE next cycle. This clears cnt, high_r, valid_o, overrun_o and timeout_o. period_o/duty_o hold their values.
- A waveform that is high H cycles and low L cycles yields period_o=H+L and duty_o=H.
- 0% duty (no fall in a period, with rise present): not possible, since a rise requires a preceding fall.
- Stuck input: if cnt reaches 2^WIDTH-1 in MEAS with no rise:
  - timeout_o<=1 (sticky), go to ARM, results unchanged, valid_o unchanged.
  - timeout_o clears on the next rise or when en_i=0.
- Handshake:
  - valid_o clears on ack_i.
  - New result while valid_o=1 and ack_i=0: results are overwritten (newest wins) and overrun_o<=1.
  - New result in the same cycle as ack_i: valid_o stays 1, overrun_o unchanged.
  - ack_i with no new result: clears valid_o and overrun_o.
- Counter never wraps; the saturation point is the timeout condition.
- pol_i change mid-measurement: treated as an input edge. Software changes pol_i only with en_i=0.
- Pulses shorter than one clock may be missed. This is a documented limitation.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A stability filter follows the synchronizer. The filtered level updates only after the synchronized input has held a new value for FILTER_LEN consecutive cycles.
  - Glitches shorter than FILTER_LEN are suppressed.
  - Both edges are delayed equally, so period and duty are unchanged. Edge latency becomes SYNC_STAGES+FILTER_LEN+1.
- Undefined: synchronizer only; no filter logic is generated.

Decomposition:
- Shared package pwm_pkg:
  - state encoding localparams (ST_IDLE=2'd0, ST_ARM=2'd1, ST_MEAS=2'd2);
  - default WIDTH;
  - the counter saturation constant.
- One sub-module, pwm_input_sync: synchronizer, optional filter, polarity XOR and rise/fall pulse generation.
- The FSM, counters, result registers and handshake stay in pwm_capture.

Test Plan:
- en=1, pol=0, input high 3 / low 5 repeating -> after the second rise, valid_o=1, period_o=8, duty_o=3; steady on later periods.
- pol=1, same waveform -> period_o=8, duty_o=5.
- Two periods completed without ack -> overrun_o=1, values equal the latest period; ack_i pulse -> valid_o=0, overrun_o=0.
- WIDTH=8, input held high after a rise -> timeout_o=1 exactly 255 cycles after the rise, state ARM; next full period -> timeout_o=0, valid result.
- en_i dropped mid-period, then re-enabled -> flags clear, first result only after two fresh rises; rst_n_i asserted mid-MEAS -> all outputs 0 immediately.
- With PWM_CAPTURE_FILTER_EN, FILTER_LEN=4, 2-cycle glitches added to a 10/10 waveform -> period_o=20, duty_o=10, no spurious valid.
